// File: rtl/ddr5_sched_pkg.sv
// Shared types, default JEDEC timings and address widths for the DDR5 command sequencer.
package ddr5_sched_pkg;

    localparam int BG_WIDTH  = 3;
    localparam int BA_WIDTH  = 2;
    localparam int ROW_WIDTH = 16;
    localparam int COL_WIDTH = 8;

    localparam int DEF_TRCD   = 39;
    localparam int DEF_TCL    = 40;
    localparam int DEF_TCWD   = 38;
    localparam int DEF_TBURST = 8;
    localparam int DEF_TRTP   = 18;
    localparam int DEF_TWR    = 48;
    localparam int DEF_TRAS   = 76;
    localparam int DEF_TRP    = 39;
    localparam int DEF_TRC    = 115;
    localparam int DEF_TRFC   = 295;
    localparam int DEF_TREFI  = 3900;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ACT_W,
        COL,
        COL_W,
        PRE_W,
        REF_W
    } state_t;

    typedef struct packed {
        logic [BG_WIDTH-1:0]  bg;
        logic [BA_WIDTH-1:0]  ba;
        logic [ROW_WIDTH-1:0] row;
        logic [COL_WIDTH-1:0] col;
    } addr_t;

    // Bits needed to hold a counter that is loaded with max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ddr5_down_counter.sv
// Saturating timing down-counter: load a value, count to zero, then hold.
// zero: constraint satisfied now; last: constraint satisfied from the next cycle.
module ddr5_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/ddr5_cmd_sequencer.sv
// Single-bank closed-page DDR5 command sequencer (ACT, RD/WR, PRE with timing counters).
// Periodic refresh insertion is built only when DDR5_REFRESH_EN is defined.
module ddr5_cmd_sequencer
    import ddr5_sched_pkg::*;
#(
    parameter int TRCD   = DEF_TRCD,
    parameter int TCL    = DEF_TCL,
    parameter int TCWD   = DEF_TCWD,
    parameter int TBURST = DEF_TBURST,
    parameter int TRTP   = DEF_TRTP,
    parameter int TWR    = DEF_TWR,
    parameter int TRAS   = DEF_TRAS,
    parameter int TRP    = DEF_TRP,
    parameter int TRC    = DEF_TRC
`ifdef DDR5_REFRESH_EN
    ,
    parameter int TRFC   = DEF_TRFC,
    parameter int TREFI  = DEF_TREFI
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BG_WIDTH-1:0]  req_bg,
    input  logic [BA_WIDTH-1:0]  req_ba,
    input  logic [ROW_WIDTH-1:0] req_row,
    input  logic [COL_WIDTH-1:0] req_col,
    output logic                 cmd_valid,
    output logic [2:0]           cmd_op,
    output logic [BG_WIDTH-1:0]  cmd_bg,
    output logic [BA_WIDTH-1:0]  cmd_ba,
    output logic [ROW_WIDTH-1:0] cmd_row,
    output logic [COL_WIDTH-1:0] cmd_col,
    output logic                 done,
    output logic                 busy
);

    // Write recovery is measured from the WR command, covering CWL and the burst.
    localparam int WR_TO_PRE = TCWD + TBURST + TWR;
    localparam int RD_DATA   = TCL + TBURST;

    localparam int TRCD_W = cnt_width(TRCD);
    localparam int TRAS_W = cnt_width(TRAS);
    localparam int TRC_W  = cnt_width(TRC);
    localparam int TRTP_W = cnt_width(TRTP);
    localparam int TWR_W  = cnt_width(WR_TO_PRE);
    localparam int RDAT_W = cnt_width(RD_DATA);
    localparam int TRP_W  = cnt_width(TRP);

    state_t  state;
    state_t  state_next;
    cmd_op_t issue_op;
    logic    accept;
    logic    done_wr;
    addr_t   req_addr;
    addr_t   addr_q;
    addr_t   cmd_addr_q;
    logic    write_q;

    logic trcd_zero, trcd_last, tras_zero, tras_last, trc_zero, trc_last;
    logic trtp_zero, trtp_last, twr_zero, twr_last, trp_zero, trp_last;
    logic rdat_zero, rdat_last;
    logic trcd_ok, tras_ok, trc_ok, trtp_ok, twr_ok, trp_ok, trfc_ok;
    logic act_ok, pre_ok, ref_pending;

    assign req_addr = {req_bg, req_ba, req_row, req_col};

    ddr5_down_counter #(.WIDTH(TRCD_W)) u_trcd (
        .clock(clock), .reset(reset), .load(issue_op == CMD_ACT),
        .value(TRCD_W'(TRCD)), .zero(trcd_zero), .last(trcd_last)
    );
    ddr5_down_counter #(.WIDTH(TRAS_W)) u_tras (
        .clock(clock), .reset(reset), .load(issue_op == CMD_ACT),
        .value(TRAS_W'(TRAS)), .zero(tras_zero), .last(tras_last)
    );
    ddr5_down_counter #(.WIDTH(TRC_W)) u_trc (
        .clock(clock), .reset(reset), .load(issue_op == CMD_ACT),
        .value(TRC_W'(TRC)), .zero(trc_zero), .last(trc_last)
    );
    ddr5_down_counter #(.WIDTH(TRTP_W)) u_trtp (
        .clock(clock), .reset(reset), .load(issue_op == CMD_RD),
        .value(TRTP_W'(TRTP)), .zero(trtp_zero), .last(trtp_last)
    );
    ddr5_down_counter #(.WIDTH(TWR_W)) u_twr (
        .clock(clock), .reset(reset), .load(issue_op == CMD_WR),
        .value(TWR_W'(WR_TO_PRE)), .zero(twr_zero), .last(twr_last)
    );
    ddr5_down_counter #(.WIDTH(RDAT_W)) u_rdat (
        .clock(clock), .reset(reset), .load(issue_op == CMD_RD),
        .value(RDAT_W'(RD_DATA)), .zero(rdat_zero), .last(rdat_last)
    );
    ddr5_down_counter #(.WIDTH(TRP_W)) u_trp (
        .clock(clock), .reset(reset), .load(issue_op == CMD_PRE),
        .value(TRP_W'(TRP)), .zero(trp_zero), .last(trp_last)
    );

    // A command may be registered when its counter is zero now or reaches zero next cycle.
    assign trcd_ok = trcd_zero | trcd_last;
    assign tras_ok = tras_zero | tras_last;
    assign trc_ok  = trc_zero  | trc_last;
    assign trtp_ok = trtp_zero | trtp_last;
    assign twr_ok  = twr_zero  | twr_last;
    assign trp_ok  = trp_zero  | trp_last;

`ifdef DDR5_REFRESH_EN
    localparam int REFI_W = cnt_width(TREFI);
    localparam int TRFC_W = cnt_width(TRFC);

    logic refi_zero, refi_last, refi_expire, trfc_zero, trfc_last;

    // Free-running interval timer: reloads itself every time it reaches zero.
    ddr5_down_counter #(.WIDTH(REFI_W)) u_refi (
        .clock(clock), .reset(reset), .load(refi_zero),
        .value(REFI_W'(TREFI - 1)), .zero(refi_zero), .last(refi_last)
    );
    ddr5_down_counter #(.WIDTH(TRFC_W)) u_trfc (
        .clock(clock), .reset(reset), .load(issue_op == CMD_REF),
        .value(TRFC_W'(TRFC)), .zero(trfc_zero), .last(trfc_last)
    );

    assign refi_expire = (TREFI == 1) ? refi_zero : refi_last;
    assign trfc_ok     = trfc_zero | trfc_last;

    // A fresh expiry coinciding with the REF issue keeps the request pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            ref_pending <= 1'b0;
        end else if (refi_expire) begin
            ref_pending <= 1'b1;
        end else if (issue_op == CMD_REF) begin
            ref_pending <= 1'b0;
        end
    end
`else
    assign ref_pending = 1'b0;
    assign trfc_ok     = 1'b1;
`endif

    assign act_ok    = trp_ok & trc_ok & trfc_ok;
    assign pre_ok    = tras_ok & (write_q ? twr_ok : trtp_ok);
    assign req_ready = !reset && (state == IDLE) && !ref_pending && act_ok;
    assign busy      = (state != IDLE) || !rdat_zero;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue_op   = CMD_NOP;
        accept     = 1'b0;
        done_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pending && act_ok) begin
                    issue_op   = CMD_REF;
                    state_next = REF_W;
                end else if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    issue_op   = CMD_ACT;
                    state_next = ACT_W;
                end
            end
            ACT_W: begin
                if (trcd_ok) begin
                    issue_op   = write_q ? CMD_WR : CMD_RD;
                    state_next = COL;
                end
            end
            COL, COL_W: begin
                if (pre_ok) begin
                    issue_op   = CMD_PRE;
                    done_wr    = write_q;
                    state_next = PRE_W;
                end else begin
                    state_next = COL_W;
                end
            end
            PRE_W, REF_W: state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    // Request fields are only consumed after an accept, so they carry no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q  <= req_addr;
            write_q <= req_write;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_valid  <= 1'b0;
            cmd_op     <= CMD_NOP;
            cmd_addr_q <= '0;
            done       <= 1'b0;
        end else begin
            cmd_valid <= (issue_op != CMD_NOP);
            cmd_op    <= issue_op;
            if (issue_op == CMD_NOP || issue_op == CMD_REF) begin
                cmd_addr_q <= '0;
            end else begin
                cmd_addr_q <= accept ? req_addr : addr_q;
            end
            done <= done_wr | rdat_last;
        end
    end

    assign cmd_bg  = cmd_addr_q.bg;
    assign cmd_ba  = cmd_addr_q.ba;
    assign cmd_row = cmd_addr_q.row;
    assign cmd_col = cmd_addr_q.col;

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Directed bench for ddr5_cmd_sequencer: command timing of read, write, back-to-back, reset abort,
// and refresh insertion when DDR5_REFRESH_EN is defined.
module tb_ddr5_cmd_sequencer;

    typedef struct {
        int t;
        int op;
        int bg;
        int row;
        int col;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_bg;
    logic [1:0]  req_ba;
    logic [15:0] req_row;
    logic [7:0]  req_col;
    logic        req_ready, cmd_valid, done, busy;
    logic [2:0]  cmd_op, cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [7:0]  cmd_col;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   t0 = 0;
    ev_t  evq[$];
    int   doneq[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

`ifdef DDR5_REFRESH_EN
    logic        r_req_ready, r_cmd_valid, r_done, r_busy;
    logic [2:0]  r_cmd_op, r_cmd_bg;
    logic [1:0]  r_cmd_ba;
    logic [15:0] r_cmd_row;
    logic [7:0]  r_cmd_col;

    ddr5_cmd_sequencer #(.TREFI(200)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .req_col(req_col), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bg(cmd_bg),
        .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col), .done(done), .busy(busy)
    );

    ddr5_cmd_sequencer dut_ref (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(r_req_ready),
        .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .req_col(req_col), .cmd_valid(r_cmd_valid), .cmd_op(r_cmd_op), .cmd_bg(r_cmd_bg),
        .cmd_ba(r_cmd_ba), .cmd_row(r_cmd_row), .cmd_col(r_cmd_col), .done(r_done),
        .busy(r_busy)
    );
`else
    ddr5_cmd_sequencer dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .req_col(req_col), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bg(cmd_bg),
        .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col), .done(done), .busy(busy)
    );
`endif

    always @(negedge clock) begin
        ev_t e;
        if (!reset) begin
            if (cmd_valid) begin
                e.t   = cyc;
                e.op  = int'(cmd_op);
                e.bg  = int'(cmd_bg);
                e.row = int'(cmd_row);
                e.col = int'(cmd_col);
                evq.push_back(e);
            end
            if (done) doneq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic at_cycle(input int t);
        do @(negedge clock); while (cyc < t);
    endtask

    function automatic int ev_idx(input int op, input int nth);
        int n = 0;
        for (int i = 0; i < evq.size(); i++) begin
            if (evq[i].op == op) begin
                if (n == nth) return i;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic int ev_rel(input int op, input int nth);
        int i = ev_idx(op, nth);
        return (i < 0) ? -1 : evq[i].t - t0;
    endfunction

    function automatic int ev_count(input int op);
        int n = 0;
        for (int i = 0; i < evq.size(); i++) if (evq[i].op == op) n++;
        return n;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_bg    = '0;
        req_ba    = '0;
        req_row   = '0;
        req_col   = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        evq.delete();
        doneq.delete();
        t0 = cyc;
    endtask

    task automatic send(input logic wr, input int bg, input int row, input int col);
        req_valid = 1'b1;
        req_write = wr;
        req_bg    = 3'(bg);
        req_ba    = 2'd2;
        req_row   = 16'(row);
        req_col   = 8'(col);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got cycle %0d expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int highs;
        int acc2;
        int ref_t;
        int act_t;

        reset = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_op", cmd_op, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_cmd_row", cmd_row, 0);

`ifndef DDR5_REFRESH_EN
        // Single read
        do_reset();
        send(1'b0, 5, 16'hBEEF, 8'h5A);
        @(negedge clock);
        check("rd_ready_idle", req_ready, 1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        req_row = '0;
        req_col = '0;
        at_cycle(t0 + 80);
        check("rd_busy_data_pending", busy, 1);
        at_cycle(t0 + 89);
        check("rd_busy_after_done", busy, 0);
        at_cycle(t0 + 150);
        check("rd_act_t", ev_rel(1, 0), 1);
        check("rd_rd_t", ev_rel(2, 0), 40);
        check("rd_pre_t", ev_rel(4, 0), 77);
        check("rd_cmd_count", evq.size(), 3);
        check("rd_done_count", doneq.size(), 1);
        check("rd_done_t", (doneq.size() > 0) ? doneq[0] - t0 : -1, 88);
        check("rd_act_row", (ev_idx(1, 0) >= 0) ? evq[ev_idx(1, 0)].row : -1, 16'hBEEF);
        check("rd_act_bg", (ev_idx(1, 0) >= 0) ? evq[ev_idx(1, 0)].bg : -1, 5);
        check("rd_rd_col", (ev_idx(2, 0) >= 0) ? evq[ev_idx(2, 0)].col : -1, 8'h5A);

        // Single write
        do_reset();
        send(1'b1, 3, 16'h1234, 8'h0F);
        @(posedge clock);
        #1 req_valid = 1'b0;
        at_cycle(t0 + 200);
        check("wr_act_t", ev_rel(1, 0), 1);
        check("wr_wr_t", ev_rel(3, 0), 40);
        check("wr_pre_t", ev_rel(4, 0), 134);
        check("wr_rd_count", ev_count(2), 0);
        check("wr_done_count", doneq.size(), 1);
        check("wr_done_t", (doneq.size() > 0) ? doneq[0] - t0 : -1, 134);
        check("wr_wr_col", (ev_idx(3, 0) >= 0) ? evq[ev_idx(3, 0)].col : -1, 8'h0F);

        // Back-to-back reads with req_valid held high
        do_reset();
        send(1'b0, 1, 16'h0001, 8'h01);
        highs = 0;
        acc2 = -1;
        for (int k = 0; k <= 120; k++) begin
            at_cycle(t0 + k);
            if (k >= 1 && k <= 114 && req_ready) highs++;
            if (k > 0 && req_ready && acc2 < 0) acc2 = k;
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        at_cycle(t0 + 300);
        check("b2b_ready_low_cycles", highs, 0);
        check("b2b_second_accept", acc2, 115);
        check("b2b_act2_t", ev_rel(1, 1), 116);
        check("b2b_rd2_t", ev_rel(2, 1), 155);
        check("b2b_act_count", ev_count(1), 2);
        check("b2b_done_count", doneq.size(), 2);

        // Reset asserted in the middle of a read
        do_reset();
        send(1'b0, 2, 16'h00AA, 8'h33);
        @(posedge clock);
        #1 req_valid = 1'b0;
        at_cycle(t0 + 50);
        check("rst50_busy_before", busy, 1);
        reset = 1'b1;
        at_cycle(t0 + 51);
        check("rst50_cmd_valid", cmd_valid, 0);
        check("rst50_cmd_op", cmd_op, 0);
        check("rst50_done", done, 0);
        check("rst50_busy", busy, 0);
        check("rst50_req_ready", req_ready, 0);
        at_cycle(t0 + 52);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst50_ready_after_release", req_ready, 1);
        at_cycle(t0 + 150);
        check("rst50_rd_seen", ev_count(2), 1);
        check("rst50_no_pre", ev_count(4), 0);
        check("rst50_no_done", doneq.size(), 0);
`else
        // Refresh from idle with TREFI=200
        do_reset();
        highs = 0;
        for (int k = 0; k <= 600; k++) begin
            at_cycle(t0 + k);
            if (k == 199) check("ref_ready_before_due", req_ready, 1);
            if (k == 200) check("ref_ready_pending", req_ready, 0);
            if (k >= 200 && k <= 495 && req_ready) highs++;
        end
        check("ref_ready_low_cycles", highs, 0);
        check("ref_first_t", ev_rel(5, 0), 201);
        check("ref_second_t", ev_rel(5, 1), 496);
        check("ref_no_act", ev_count(1), 0);
        check("ref_row_zero", (ev_idx(5, 0) >= 0) ? evq[ev_idx(5, 0)].row : -1, 0);

        // Refresh due while a request waits (default TREFI instance)
        do_reset();
        at_cycle(t0 + 3899);
        check("refq_ready_before_due", r_req_ready, 1);
        at_cycle(t0 + 3900);
        check("refq_ready_pending", r_req_ready, 0);
        send(1'b0, 4, 16'h7777, 8'h11);
        ref_t = -1;
        act_t = -1;
        for (int k = 3901; k <= 4300; k++) begin
            at_cycle(t0 + k);
            if (r_cmd_valid && r_cmd_op == 3'd5 && ref_t < 0) ref_t = k;
            if (r_cmd_valid && r_cmd_op == 3'd1 && act_t < 0) begin
                act_t = k;
                req_valid = 1'b0;
                check("refq_act_row", r_cmd_row, 16'h7777);
            end
        end
        req_valid = 1'b0;
        check("refq_ref_t", ref_t, 3901);
        check("refq_act_t", act_t, 4196);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr5_cmd_sequencer.md
# ddr5_cmd_sequencer

Single-bank closed-page DDR5 command sequencer that sits between the request queue head and the DIMM command bus. It accepts one request at a time, emits the ACT, RD/WR and PRE commands, and spaces them with internal down-counters for every JEDEC timing constraint. Completion is signalled with a one-cycle done pulse, and periodic refresh is optionally inserted.

## Interface
- TRCD, 39, ACT to RD/WR, in clocks
- TCL, 40, RD to first data
- TCWD, 38, WR to first data
- TBURST, 8, data burst length
- TRTP, 18, RD to PRE
- TWR, 48, end of write burst to PRE
- TRAS, 76, ACT to PRE minimum
- TRP, 39, PRE to next ACT/REF
- TRC, 115, ACT to next ACT/REF
- TRFC, 295, REF to next ACT/REF
- TREFI, 3900, refresh interval
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present at queue head
- req_ready  out  1  sequencer accepts the request this cycle
- req_write  in  1  1 = write, 0 = read
- req_bg / req_ba / req_row / req_col  in  3/2/16/8  mapped address fields
- cmd_valid  out  1  command strobe, one cycle
- cmd_op  out  3  NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5
- cmd_bg / cmd_ba / cmd_row / cmd_col  out  3/2/16/8  command address; zero for REF
- done  out  1  one-cycle pulse when the transaction completes
- busy  out  1  FSM not in IDLE, or a read-data counter is running

## Operation
- FSM states: IDLE, ACT_W, COL, COL_W, PRE_W, REF_W.
- Reset value of every output is 0, with cmd_op=NOP. All counters are cleared and the FSM goes to IDLE.
- IDLE: req_ready=1 only when no refresh is pending and an ACT at the next cycle is legal (the tRP, tRC and tRFC counters will be 0).
- Handshake: a request is accepted in cycle T when req_valid && req_ready. Its fields are latched, ACT issues at T+1, and the FSM enters ACT_W.
- ACT_W: on ACT, load the tRCD, tRAS and tRC counters. The RD/WR command issues in the cycle tRCD expires, at ACT+TRCD.
- Read: on RD, load tRTP and a read-data counter of TCL+TBURST. PRE issues at max(RD+TRTP, ACT+TRAS). done pulses at RD+TCL+TBURST, independently of the FSM, which may already be back in IDLE.
- Write: PRE issues at max(WR+TCWD+TBURST+TWR, ACT+TRAS). done pulses in the same cycle as the PRE.
- PRE: load tRP, then return to IDLE. The next ACT is gated by both tRP and tRC.
- At most one command per cycle. cmd_valid=0 and cmd_op=NOP in every non-issue cycle.
- Counters are saturating down-counters: load the value, decrement to 0, then hold. Each counter is $clog2(max+1) bits wide.
- All timing parameters must be ≥1.
- Reset asserted mid-operation: the FSM aborts with no PRE. A pending read done is suppressed.

## Timing
- Latency from accept to ACT is 1 cycle. From accept to RD/WR it is 1+TRCD.
- Read done arrives 1+TRCD+TCL+TBURST cycles after accept. With defaults this is 88.
- Refresh pending and req_valid in the same IDLE cycle: REF wins, and req_ready=0.
- cmd_* outputs are registered.

## Configuration
- DDR5_REFRESH_EN defined:
  - A free-running TREFI counter runs from reset release and sets sticky ref_pending when it expires; the counter then reloads.
  - In IDLE with tRP=tRC=0, REF issues, tRFC is loaded, and the FSM goes to REF_W then IDLE.
  - A pending refresh does not wait for an in-flight read done.
  - A further expiry while ref_pending is still set is absorbed; there is no postponement credit.
- DDR5_REFRESH_EN undefined: no refresh logic. REF is never issued, and REF_W is unreachable.

## Structure
- Package ddr5_sched_pkg holds:
  - the cmd_op_t enum;
  - the FSM state enum;
  - default timing localparams;
  - the address field widths.
- One sub-module, ddr5_down_counter, is parameterised by width and provides load, saturating decrement and a zero flag. It is instantiated once per timing constraint.

## Test plan
- Reset, then a single read accepted at cycle 0 -> ACT@1, RD@40, PRE@77, done@88. cmd_row and cmd_col echo the request.
- Single write accepted at 0 -> ACT@1, WR@40, PRE@134, done@134.
- Back-to-back reads, req_valid held high -> second accept at 115, second ACT@116. req_ready stays low during cycles 1–114.
- Reset asserted at cycle 50 during a read -> outputs 0 on the next cycle, no PRE, no done. req_ready=1 one cycle after release.
- DDR5_REFRESH_EN with TREFI=200, idle -> REF issues at cycle 201. req_ready stays low until 201+TRFC-1.
- DDR5_REFRESH_EN, refresh due while req_valid=1 in IDLE -> REF issues first. The request's ACT issues at REF+TRFC.
